// File: rtl/equiv_check_sequencer_pkg.sv
// equiv_pkg: shared types, constants and helpers for the equivalence-check
// sequencer.
//   - state_t     : sequencer FSM states
//   - stimulus    : widths and LSB offsets of wire0..wire4 inside the
//                   79-bit stimulus word S = {A, B, C[14:0]}
//   - LFSR_POLY   : Galois feedback taps for x^32+x^22+x^2+x+1
//   - SEED_XOR_*  : constants that decorrelate LFSRs B and C from A
//   - lfsr_next / seed_fix / stim_pack : small pure helpers
package equiv_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int Y_W_DEF   = 91;

  localparam logic [31:0] LFSR_POLY  = 32'h80200003;
  localparam logic [31:0] SEED_XOR_B = 32'hA5A5A5A5;
  localparam logic [31:0] SEED_XOR_C = 32'h5A5A5A5A;

  localparam int STIM_W = 79;
  localparam int C_BITS = 15;

  localparam int W0_W = 18;
  localparam int W1_W = 17;
  localparam int W2_W = 15;
  localparam int W3_W = 10;
  localparam int W4_W = 19;

  localparam int W0_LSB = 0;
  localparam int W1_LSB = 18;
  localparam int W2_LSB = 35;
  localparam int W3_LSB = 50;
  localparam int W4_LSB = 60;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Right-shifting Galois step: the shifted-out bit folds the taps back in.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  function automatic logic [31:0] seed_fix(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  function automatic logic [STIM_W-1:0] stim_pack(input logic [31:0] a,
                                                  input logic [31:0] b,
                                                  input logic [31:0] c);
    return {a, b, c[C_BITS-1:0]};
  endfunction

endpackage

// File: rtl/equiv_check_sequencer_if.sv
// equiv_check_sequencer_if: bundles the control, stimulus, response and
// report signals of the equivalence-check sequencer.
//   master : harness side (drives start/num_vectors/seed and y_1/y_2)
//   slave  : sequencer side (drives wire0..wire4 and the report)
//
// Handshake: start is a single-cycle request with no ready; it is accepted
// only while the sequencer is idle or done (busy low), and num_vectors/seed
// are sampled in that same cycle. busy high means the request was taken and
// any further start is ignored until busy falls and done rises.
interface equiv_check_sequencer_if #(
  parameter int CNT_W = 16,
  parameter int Y_W   = 91
);
  import equiv_pkg::*;

  logic                start;
  logic [CNT_W-1:0]    num_vectors;
  logic [31:0]         seed;

  logic [17:0]         wire0;
  logic [16:0]         wire1;
  logic signed [14:0]  wire2;
  logic signed [9:0]   wire3;
  logic signed [18:0]  wire4;

  logic [Y_W-1:0]      y_1;
  logic [Y_W-1:0]      y_2;

  logic                busy;
  logic                done;
  logic                pass;
  logic [CNT_W-1:0]    mismatch_count;
  logic [CNT_W-1:0]    first_fail_idx;
  logic [Y_W-1:0]      first_fail_diff;
  state_t              state_dbg;

  modport master (
    output start, num_vectors, seed, y_1, y_2,
    input  wire0, wire1, wire2, wire3, wire4,
    input  busy, done, pass, mismatch_count, first_fail_idx,
    input  first_fail_diff, state_dbg
  );

  modport slave (
    input  start, num_vectors, seed, y_1, y_2,
    output wire0, wire1, wire2, wire3, wire4,
    output busy, done, pass, mismatch_count, first_fail_idx,
    output first_fail_diff, state_dbg
  );

endinterface

// File: rtl/equiv_check_sequencer_lfsr32.sv
// lfsr32: 32-bit Galois LFSR with synchronous load and step.
//   clk, rst : clock, synchronous active-high reset (state -> 0)
//   load     : load seed (zero seed becomes 1); has priority over step
//   step     : advance one position
//   seed     : load value
//   state    : current register contents
module lfsr32
  import equiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] seed,
  output logic [31:0] state
);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= 32'h0;
    end else if (load) begin
      state <= seed_fix(seed);
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/equiv_check_sequencer.sv
// equiv_check_sequencer: bounded, self-checking stimulus run for the
// equivalence harness. Drives wire0..wire4 of both implementations from three
// seeded LFSRs for num_vectors vectors, compares y_1 with y_2 LAT cycles after
// each vector and reports pass/fail, a saturating mismatch count and the
// first failing vector.
//   clk, rst           : clock, synchronous active-high reset
//   bus.start          : one-cycle run request (accepted when idle/done)
//   bus.num_vectors    : vectors to apply, sampled on start
//   bus.seed           : LFSR seed, sampled on start
//   bus.wire0..wire4   : registered stimulus
//   bus.y_1, bus.y_2   : implementation outputs
//   bus.busy           : high from LOAD through DRAIN
//   bus.done/pass      : sticky run result
//   bus.mismatch_count / first_fail_idx / first_fail_diff : report
//   bus.state_dbg      : current FSM state
module equiv_check_sequencer
  import equiv_pkg::*;
#(
  parameter int LAT   = 1,
  parameter int CNT_W = CNT_W_DEF,
  parameter int Y_W   = Y_W_DEF
) (
  input logic                    clk,
  input logic                    rst,
  equiv_check_sequencer_if.slave bus
);

  // The tag pipe needs at least one stage to exist even when LAT is 0.
  localparam int               PIPE_D     = (LAT > 0) ? LAT : 1;
  localparam logic [3:0]       DRAIN_LAST = 4'((LAT > 0) ? LAT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t              state;
  logic [CNT_W-1:0]    n_r;
  logic [31:0]         seed_r;
  logic [CNT_W-1:0]    vec_cnt;
  logic [3:0]          drain_cnt;
  logic [STIM_W-1:0]   stim_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic [CNT_W-1:0]    mm_q;
  logic [CNT_W-1:0]    ffi_q;
  logic [Y_W-1:0]      ffd_q;

  // ---------------------------------------------------------------- LFSRs
  logic        lfsr_load;
  logic        lfsr_step;
  logic [31:0] seed_b;
  logic [31:0] seed_c;
  logic [31:0] a_q, b_q, c_q;

  assign lfsr_load = (state == LOAD);
  assign lfsr_step = (state == RUN);
  assign seed_b    = seed_r ^ SEED_XOR_B;
  assign seed_c    = seed_r ^ SEED_XOR_C;

  lfsr32 u_lfsr_a (.clk(clk), .rst(rst), .load(lfsr_load), .step(lfsr_step),
                   .seed(seed_r), .state(a_q));
  lfsr32 u_lfsr_b (.clk(clk), .rst(rst), .load(lfsr_load), .step(lfsr_step),
                   .seed(seed_b), .state(b_q));
  lfsr32 u_lfsr_c (.clk(clk), .rst(rst), .load(lfsr_load), .step(lfsr_step),
                   .seed(seed_c), .state(c_q));

  // ---------------------------------------------------- compare tag pipe
  // Vector k sits on the ports during RUN cycle k; its tag enters stage 0 at
  // the end of that cycle and leaves stage LAT-1 exactly LAT cycles later,
  // which is when the implementations present its result.
  logic [PIPE_D-1:0] pv;
  logic [CNT_W-1:0]  pidx [PIPE_D];

  always_ff @(posedge clk) begin
    if (rst) begin
      pv <= '0;
      for (int j = 0; j < PIPE_D; j++) pidx[j] <= '0;
    end else begin
      pv[0]   <= (state == RUN);
      pidx[0] <= vec_cnt;
      for (int j = 1; j < PIPE_D; j++) begin
        pv[j]   <= pv[j-1];
        pidx[j] <= pidx[j-1];
      end
    end
  end

  logic             cmp_valid;
  logic [CNT_W-1:0] cmp_idx;
  logic [Y_W-1:0]   diff;
  logic             fail;
  logic [CNT_W-1:0] mm_next;

  always_comb begin
    cmp_valid = 1'b0;
    cmp_idx   = '0;
    if (LAT == 0) begin
      cmp_valid = (state == RUN);
      cmp_idx   = vec_cnt;
    end else begin
      cmp_valid = pv[PIPE_D-1];
      cmp_idx   = pidx[PIPE_D-1];
    end
    diff    = bus.y_1 ^ bus.y_2;
    fail    = cmp_valid && (diff != '0);
    mm_next = mm_q;
    if (fail && (mm_q != CNT_MAX)) mm_next = mm_q + 1'b1;
  end

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      n_r       <= '0;
      seed_r    <= '0;
      vec_cnt   <= '0;
      drain_cnt <= '0;
      stim_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      mm_q      <= '0;
      ffi_q     <= '0;
      ffd_q     <= '0;
    end else begin
      // Result capture; mm_q still zero means no earlier failure this run.
      if (fail) begin
        mm_q <= mm_next;
        if (mm_q == '0) begin
          ffi_q <= cmp_idx;
          ffd_q <= diff;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            n_r     <= bus.num_vectors;
            seed_r  <= bus.seed;
            vec_cnt <= '0;
            mm_q    <= '0;
            ffi_q   <= '0;
            ffd_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
            state   <= LOAD;
          end
        end

        LOAD: begin
          // Vector 0 goes straight from the fixed seeds so it is on the
          // ports during the first RUN cycle.
          stim_q  <= stim_pack(seed_fix(seed_r), seed_fix(seed_b),
                               seed_fix(seed_c));
          vec_cnt <= '0;
          if (n_r == '0) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= 1'b1;
            state  <= DONE;
          end else begin
            state <= RUN;
          end
        end

        RUN: begin
          // vec_cnt stops at n_r-1, so an all-ones count never wraps.
          if (vec_cnt == n_r - 1'b1) begin
            if (LAT > 0) begin
              drain_cnt <= '0;
              state     <= DRAIN;
            end else begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              pass_q <= (mm_next == '0);
              state  <= DONE;
            end
          end else begin
            vec_cnt <= vec_cnt + 1'b1;
            stim_q  <= stim_pack(lfsr_next(a_q), lfsr_next(b_q),
                                 lfsr_next(c_q));
          end
        end

        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (mm_next == '0);
            state  <= DONE;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------- outputs
  assign bus.wire0           = stim_q[W0_LSB +: W0_W];
  assign bus.wire1           = stim_q[W1_LSB +: W1_W];
  assign bus.wire2           = stim_q[W2_LSB +: W2_W];
  assign bus.wire3           = stim_q[W3_LSB +: W3_W];
  assign bus.wire4           = stim_q[W4_LSB +: W4_W];
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.mismatch_count  = mm_q;
  assign bus.first_fail_idx  = ffi_q;
  assign bus.first_fail_diff = ffd_q;
  assign bus.state_dbg       = state;

endmodule

// File: tb/tb_equiv_check_sequencer.sv
// Testbench for equiv_check_sequencer: two behavioural implementations with
// a one-cycle register, a reference stimulus generator and per-scenario tasks.
module tb_equiv_check_sequencer;
  import equiv_pkg::*;

  localparam int LAT   = 1;
  localparam int CNT_W = 16;
  localparam int Y_W   = 91;
  localparam int SW    = 79;

  // ------------------------------------------------------ clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  equiv_check_sequencer_if #(.CNT_W(CNT_W), .Y_W(Y_W)) bus ();

  equiv_check_sequencer #(.LAT(LAT), .CNT_W(CNT_W), .Y_W(Y_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ------------------------------------------------------- bench state
  int total = 0;
  int bad   = 0;
  int fault_mode = 0;                 // 0 equal, 1 per-vector flips, 2 all wrong
  logic [SW-1:0]  exp_q[$];           // expected stimulus per vector
  logic [SW-1:0]  obs_q[$];           // observed stimulus per RUN cycle
  int             s2idx[logic [SW-1:0]];
  logic [Y_W-1:0] flip_by_idx[int];

  function automatic logic [SW-1:0] cur_stim();
    return {bus.wire4, bus.wire3, bus.wire2, bus.wire1, bus.wire0};
  endfunction

  // ------------------------------------------- implementation models
  always @(posedge clk) begin
    logic [SW-1:0]  sv;
    logic [Y_W-1:0] yv;
    logic [Y_W-1:0] fl;
    sv = cur_stim();
    yv = {sv[11:0] ^ sv[78:67], sv};
    fl = '0;
    if (fault_mode == 2) fl = '1;
    else if (fault_mode == 1 && s2idx.exists(sv))
      if (flip_by_idx.exists(s2idx[sv])) fl = flip_by_idx[s2idx[sv]];
    bus.y_1 <= yv;
    bus.y_2 <= yv ^ fl;
  end

  // ---------------------------------------------- reference stimulus
  function automatic logic [31:0] ref_step(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h80200003;
    return r;
  endfunction

  task automatic gen_model(input logic [31:0] s, input int n);
    logic [31:0] a, b, c;
    a = (s == 0) ? 32'h1 : s;
    b = ((s ^ 32'hA5A5A5A5) == 0) ? 32'h1 : (s ^ 32'hA5A5A5A5);
    c = ((s ^ 32'h5A5A5A5A) == 0) ? 32'h1 : (s ^ 32'h5A5A5A5A);
    exp_q.delete();
    s2idx.delete();
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({a, b, c[14:0]});
      s2idx[{a, b, c[14:0]}] = k;
      a = ref_step(a);
      b = ref_step(b);
      c = ref_step(c);
    end
  endtask

  // Counts positions where observed and expected stimulus differ.
  function automatic int stim_diffs(input int n_cmp, output int first_k);
    int nd;
    nd = 0;
    first_k = -1;
    if (obs_q.size() != n_cmp) nd++;
    for (int k = 0; k < n_cmp && k < obs_q.size() && k < exp_q.size(); k++)
      if (obs_q[k] !== exp_q[k]) begin
        nd++;
        if (first_k < 0) first_k = k;
      end
    return nd;
  endfunction

  // ------------------------------------------------------------ driver
  // Pulses start, then records one stimulus word per RUN cycle until done.
  // glitch_at >= 0 pulses start again during RUN vector glitch_at;
  // abort_at >= 0 raises rst during RUN vector abort_at and returns one
  // cycle later with rst still high.
  task automatic run_vectors(input logic [31:0] s, input int n,
                             input int glitch_at, input int abort_at,
                             output int busy_cnt, output bit done_in_load);
    int cyc;
    int limit;
    obs_q.delete();
    @(negedge clk);
    bus.start       = 1'b1;
    bus.num_vectors = CNT_W'(n);
    bus.seed        = s;
    @(negedge clk);
    bus.start       = 1'b0;
    bus.num_vectors = CNT_W'($urandom);
    bus.seed        = $urandom;
    done_in_load    = bus.done;
    busy_cnt = 0;
    cyc      = 0;
    limit    = n + LAT + 20;
    while (!bus.done && cyc < limit) begin
      if (bus.busy) begin
        if (busy_cnt >= 1 && busy_cnt <= n) obs_q.push_back(cur_stim());
        busy_cnt++;
      end
      if (abort_at >= 0 && busy_cnt == abort_at + 2) begin
        rst = 1'b1;
        @(negedge clk);
        return;
      end
      bus.start = (glitch_at >= 0 && busy_cnt == glitch_at + 2);
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    total++;
    if (!bus.done) begin
      bad++;
      $display("FAIL run_timeout seed=%h n=%0d cycles=%0d done=%b want done=1",
               s, n, cyc, bus.done);
    end
  endtask

  // --------------------------------------------------------- scenarios
  task automatic test_reset();
    bus.start = 1'b0;
    bus.num_vectors = '0;
    bus.seed = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (cur_stim() !== '0) begin
      bad++; $display("FAIL reset_wires got=%h want=0", cur_stim());
    end
    total++;
    if ({bus.busy, bus.done, bus.pass} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got busy/done/pass=%b%b%b want=000",
                      bus.busy, bus.done, bus.pass);
    end
    total++;
    if (bus.mismatch_count !== '0 || bus.first_fail_idx !== '0 ||
        bus.first_fail_diff !== '0) begin
      bad++; $display("FAIL reset_report got mm=%0d idx=%0d diff=%h want all 0",
                      bus.mismatch_count, bus.first_fail_idx, bus.first_fail_diff);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.state_dbg !== IDLE || bus.busy !== 1'b0) begin
      bad++; $display("FAIL reset_idle got state=%0d busy=%b want state=0 busy=0",
                      bus.state_dbg, bus.busy);
    end
  endtask

  task automatic test_basic();
    int bc, nd, fk;
    bit dl;
    fault_mode = 0;
    flip_by_idx.delete();
    gen_model(32'h1, 100);
    run_vectors(32'h1, 100, -1, -1, bc, dl);
    total++;
    if (bc != 102) begin
      bad++; $display("FAIL basic_busy_cycles got=%0d want=102", bc);
    end
    total++;
    if (bus.done !== 1'b1 || bus.pass !== 1'b1 || bus.mismatch_count !== '0) begin
      bad++; $display("FAIL basic_result got done=%b pass=%b mm=%0d want 1 1 0",
                      bus.done, bus.pass, bus.mismatch_count);
    end
    nd = stim_diffs(100, fk);
    total++;
    if (nd != 0) begin
      bad++; $display("FAIL basic_stim got diffs=%0d first_at=%0d want diffs=0", nd, fk);
    end
  endtask

  task automatic test_single_fault();
    int bc;
    bit dl;
    fault_mode = 1;
    flip_by_idx.delete();
    flip_by_idx[37] = Y_W'(1);
    gen_model(32'hC0FFEE01, 80);
    run_vectors(32'hC0FFEE01, 80, -1, -1, bc, dl);
    total++;
    if (dl !== 1'b0) begin
      bad++; $display("FAIL fault_done_cleared got done_in_load=%b want=0", dl);
    end
    total++;
    if (bus.mismatch_count !== 16'd1 || bus.first_fail_idx !== 16'd37) begin
      bad++; $display("FAIL fault_count got mm=%0d idx=%0d want mm=1 idx=37",
                      bus.mismatch_count, bus.first_fail_idx);
    end
    total++;
    if (bus.first_fail_diff !== Y_W'(1) || bus.pass !== 1'b0 || bus.done !== 1'b1) begin
      bad++; $display("FAIL fault_diff got diff=%h pass=%b done=%b want diff=1 pass=0 done=1",
                      bus.first_fail_diff, bus.pass, bus.done);
    end
  endtask

  task automatic test_zero_seed();
    int bc, nd, fk;
    bit dl;
    logic [31:0] seeds[2];
    fault_mode = 0;
    seeds[0] = 32'h0;
    seeds[1] = 32'hA5A5A5A5;
    for (int t = 0; t < 2; t++) begin
      gen_model(seeds[t], 20);
      run_vectors(seeds[t], 20, -1, -1, bc, dl);
      nd = stim_diffs(20, fk);
      total++;
      if (nd != 0) begin
        bad++; $display("FAIL zero_seed_stim seed=%h got diffs=%0d first_at=%0d want diffs=0",
                        seeds[t], nd, fk);
      end
      total++;
      if (bus.pass !== 1'b1) begin
        bad++; $display("FAIL zero_seed_pass seed=%h got=%b want=1", seeds[t], bus.pass);
      end
    end
  endtask

  task automatic test_zero_n();
    int bc;
    bit dl;
    fault_mode = 2;                   // would fail any compare that happened
    run_vectors(32'h1234, 0, -1, -1, bc, dl);
    total++;
    if (bc != 1) begin
      bad++; $display("FAIL zero_n_busy got=%0d want=1", bc);
    end
    total++;
    if (bus.done !== 1'b1 || bus.pass !== 1'b1 || bus.mismatch_count !== '0) begin
      bad++; $display("FAIL zero_n_result got done=%b pass=%b mm=%0d want 1 1 0",
                      bus.done, bus.pass, bus.mismatch_count);
    end
  endtask

  task automatic test_start_ignored();
    int bc, nd, fk;
    bit dl;
    fault_mode = 0;
    gen_model(32'h12345678, 50);
    run_vectors(32'h12345678, 50, 5, -1, bc, dl);
    total++;
    if (bc != 52) begin
      bad++; $display("FAIL start_ignored_busy got=%0d want=52", bc);
    end
    nd = stim_diffs(50, fk);
    total++;
    if (nd != 0) begin
      bad++; $display("FAIL start_ignored_stim got diffs=%0d first_at=%0d want diffs=0", nd, fk);
    end
  endtask

  task automatic test_reset_mid_run();
    int bc, nd, fk;
    bit dl;
    fault_mode = 0;
    gen_model(32'hDEADBEEF, 40);
    run_vectors(32'hDEADBEEF, 40, -1, 10, bc, dl);
    total++;
    if (bus.state_dbg !== IDLE || cur_stim() !== '0 ||
        {bus.busy, bus.done, bus.pass} !== 3'b000 || bus.mismatch_count !== '0) begin
      bad++; $display("FAIL abort_outputs got state=%0d wires=%h bdp=%b%b%b mm=%0d want idle and all 0",
                      bus.state_dbg, cur_stim(), bus.busy, bus.done, bus.pass,
                      bus.mismatch_count);
    end
    nd = stim_diffs(11, fk);
    total++;
    if (nd != 0) begin
      bad++; $display("FAIL abort_partial_stim got diffs=%0d first_at=%0d want diffs=0", nd, fk);
    end
    rst = 1'b0;
    run_vectors(32'hDEADBEEF, 40, -1, -1, bc, dl);
    nd = stim_diffs(40, fk);
    total++;
    if (nd != 0 || bc != 42 || bus.pass !== 1'b1) begin
      bad++; $display("FAIL abort_rerun got diffs=%0d busy=%0d pass=%b want 0 42 1",
                      nd, bc, bus.pass);
    end
  endtask

  task automatic test_random();
    int bc, nd, fk, n, exp_first, nflt;
    bit dl;
    logic [31:0]    s;
    logic [Y_W-1:0] m, exp_diff;
    fault_mode = 1;
    for (int r = 0; r < 4; r++) begin
      s = $urandom;
      n = $urandom_range(1, 150);
      flip_by_idx.delete();
      for (int k = 0; k < n; k++)
        if ($urandom_range(0, 7) == 0) begin
          m = Y_W'({$urandom, $urandom, $urandom});
          if (m == '0) m = Y_W'(1);
          flip_by_idx[k] = m;
        end
      nflt = flip_by_idx.num();
      exp_first = 0;
      exp_diff  = '0;
      if (flip_by_idx.first(exp_first)) exp_diff = flip_by_idx[exp_first];
      gen_model(s, n);
      run_vectors(s, n, -1, -1, bc, dl);
      total++;
      if (bc != n + 1 + LAT) begin
        bad++; $display("FAIL rand_busy seed=%h n=%0d got=%0d want=%0d", s, n, bc, n + 1 + LAT);
      end
      total++;
      if (bus.mismatch_count !== CNT_W'(nflt) || bus.pass !== (nflt == 0)) begin
        bad++; $display("FAIL rand_count seed=%h got mm=%0d pass=%b want mm=%0d pass=%b",
                        s, bus.mismatch_count, bus.pass, nflt, nflt == 0);
      end
      total++;
      if (bus.first_fail_idx !== CNT_W'(exp_first) || bus.first_fail_diff !== exp_diff) begin
        bad++; $display("FAIL rand_first seed=%h got idx=%0d diff=%h want idx=%0d diff=%h",
                        s, bus.first_fail_idx, bus.first_fail_diff, exp_first, exp_diff);
      end
      nd = stim_diffs(n, fk);
      total++;
      if (nd != 0) begin
        bad++; $display("FAIL rand_stim seed=%h got diffs=%0d first_at=%0d want diffs=0", s, nd, fk);
      end
    end
  endtask

  // All-ones vector count with every compare failing.
  task automatic test_saturate();
    int bc;
    bit dl;
    fault_mode = 2;
    run_vectors(32'h5, 65535, -1, -1, bc, dl);
    total++;
    if (bc != 65537) begin
      bad++; $display("FAIL sat_busy got=%0d want=65537", bc);
    end
    total++;
    if (bus.mismatch_count !== 16'hFFFF || bus.first_fail_idx !== 16'd0) begin
      bad++; $display("FAIL sat_count got mm=%h idx=%0d want mm=ffff idx=0",
                      bus.mismatch_count, bus.first_fail_idx);
    end
    total++;
    if (bus.first_fail_diff !== {Y_W{1'b1}} || bus.pass !== 1'b0) begin
      bad++; $display("FAIL sat_diff got diff=%h pass=%b want all ones, pass=0",
                      bus.first_fail_diff, bus.pass);
    end
  endtask

  // ------------------------------------------------------------- main
  initial begin
    test_reset();
    test_basic();
    test_single_fault();
    test_zero_seed();
    test_zero_n();
    test_start_ignored();
    test_reset_mid_run();
    test_random();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
